// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the MAC/FIFO sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FILLA = 3'd2,
    S_FILLB = 3'd3,
    S_EXEC  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } seq_state_t;

  localparam int N_DEF       = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 8;
  localparam int ADDR_W_DEF  = 32;
  localparam int MAC_LAT_DEF = 3;
  localparam int B_ADDR_DEF  = 8;
  localparam int TIMEOUT_CYC = 1000;

endpackage

// File: rtl/word_serializer.sv
// Latches one memory word and emits its DATA_W slices, lowest first, one per
// non-stalled cycle; last marks the final slice.
module word_serializer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DEPTH*DATA_W-1:0] din,
  input  logic                    stall,
  output logic [DATA_W-1:0]       dout,
  output logic                    vld,
  output logic                    last
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH*DATA_W-1:0] word_q;
  logic [CW-1:0]           idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
      vld    <= 1'b0;
    end else if (load) begin
      word_q <= din;
      idx_q  <= '0;
      vld    <= 1'b1;
    end else if (vld && !stall) begin
      if (last) vld <= 1'b0;
      else      idx_q <= idx_q + CW'(1);
    end
  end

  assign dout = word_q[idx_q*DATA_W +: DATA_W];
  assign last = (idx_q == CW'(DEPTH - 1));

endmodule

// File: rtl/mac_fifo_sequencer.sv
// Fetches A rows and the B row, serialises them into the FIFOs, then pops the
// FIFOs in lockstep into the MAC lanes. Optional read watchdog: SEQ_READ_TIMEOUT_EN.
module mac_fifo_sequencer
  import mac_seq_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int B_ADDR  = B_ADDR_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [ADDR_W-1:0]       mem_address,
  output logic                    mem_read,
  input  logic                    mem_waitrequest,
  input  logic [DEPTH*DATA_W-1:0] mem_readdata,
  input  logic                    mem_readdatavalid,
  output logic [DATA_W-1:0]       fifo_wdata,
  output logic [N-1:0]            wrenA,
  output logic                    wrenB,
  input  logic [N-1:0]            fullA,
  input  logic                    fullB,
  input  logic [N-1:0]            emptyA,
  input  logic                    emptyB,
  output logic [N-1:0]            rdenA,
  output logic                    rdenB,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    cout_capture,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int RW = $clog2(N + 1);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int DW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  seq_state_t  state_q, state_d;
  logic [RW-1:0] row_q;
  logic [PW-1:0] pops_q;
  logic [DW-1:0] dcnt_q;
  logic          acc_q;

  logic [N-1:0]  row_oh;
  logic          is_b, filling, full_tgt, take, pop, start_ok, rdv, wr_pend, timeout;
  logic          ser_load, ser_stall, ser_vld, ser_last;
  logic [DATA_W-1:0] ser_byte;

  assign row_oh   = {{(N-1){1'b0}}, 1'b1} << row_q;
  assign is_b     = (row_q == RW'(N));
  assign filling  = (state_q == S_FILLA) || (state_q == S_FILLB);
  assign full_tgt = (state_q == S_FILLB) ? fullB : |(fullA & row_oh);
  assign take     = filling && ser_vld && !full_tgt;
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Data is only taken once our own request has been accepted.
  assign rdv      = (state_q == S_REQ) && acc_q && mem_readdatavalid;
  // The last byte's write lands a cycle late; hold off reads/pops until it has.
  assign wr_pend  = |wrenA || wrenB;
  assign pop      = (state_q == S_EXEC) && !(|emptyA) && !emptyB && !wr_pend;

  assign ser_load  = rdv;
  assign ser_stall = !filling || full_tgt;

  word_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ser (
    .clk  (clk),
    .rst  (rst),
    .load (ser_load),
    .din  (mem_readdata),
    .stall(ser_stall),
    .dout (ser_byte),
    .vld  (ser_vld),
    .last (ser_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_REQ;
      S_REQ: begin
        if (timeout)  state_d = S_DONE;
        else if (rdv) state_d = is_b ? S_FILLB : S_FILLA;
      end
      S_FILLA: if (take && ser_last) state_d = S_REQ;
      S_FILLB: if (take && ser_last) state_d = S_EXEC;
      S_EXEC:  if (pop && (pops_q == PW'(DEPTH - 1))) state_d = S_DRAIN;
      S_DRAIN: if (dcnt_q == DW'(MAC_LAT)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_read     = (state_q == S_REQ) && !acc_q && !wr_pend;
  assign mem_address  = (state_q != S_REQ) ? '0 :
                        is_b ? ADDR_W'(B_ADDR) : ADDR_W'(row_q);
  assign rdenA        = {N{pop}};
  assign rdenB        = pop;
  assign cout_capture = (state_q == S_DRAIN) && (dcnt_q == DW'(MAC_LAT));
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      pops_q     <= '0;
      dcnt_q     <= '0;
      acc_q      <= 1'b0;
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      wrenA      <= '0;
      wrenB      <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      mac_clr <= start_ok;
      mac_en  <= pop;
      wrenA   <= (take && state_q == S_FILLA) ? row_oh : '0;
      wrenB   <= take && (state_q == S_FILLB);
      if (take) fifo_wdata <= ser_byte;
      if (start_ok) begin
        row_q  <= '0;
        pops_q <= '0;
        dcnt_q <= '0;
        acc_q  <= 1'b0;
      end
      if (mem_read && !mem_waitrequest) acc_q <= 1'b1;
      if (rdv || timeout) acc_q <= 1'b0;
      if (take && ser_last && state_q == S_FILLA) row_q <= row_q + RW'(1);
      if (pop) pops_q <= pops_q + PW'(1);
      if (state_q == S_DRAIN) dcnt_q <= dcnt_q + DW'(1);
    end
  end

`ifdef SEQ_READ_TIMEOUT_EN
  logic [15:0] wd_q;

  assign timeout = (state_q == S_REQ) && !rdv && (wd_q == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
      err  <= 1'b0;
    end else begin
      wd_q <= (state_q == S_REQ && !rdv) ? wd_q + 16'd1 : 16'd0;
      if (start_ok)     err <= 1'b0;
      else if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: doc/mac_fifo_sequencer.md
Name: mac_fifo_sequencer

Overview:
Top-level controller for the MAC/FIFO datapath. It reads the A matrix (N rows) and the B vector (1 row) from on-chip memory, serialises each memory word into bytes and writes them into the N A-FIFOs and the B-FIFO. It then pops all FIFOs in lockstep to drive the N MAC lanes and pulses a capture strobe so that the Cout registers latch the final sums.

Parameters:
N, 8, number of A-FIFOs / MAC lanes (A rows)
DATA_W, 8, FIFO entry width; memory word width = DEPTH*DATA_W
DEPTH, 8, FIFO depth = bytes per memory word = MAC terms per lane
ADDR_W, 32, memory address width
MAC_LAT, 3, cycles from last mac_en to a valid MAC result
B_ADDR, 8, word address of the B row (A row i is at address i)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
mem_address  out  ADDR_W  word address
mem_read  out  1  read request; held until accepted
mem_waitrequest  in  1  memory stall; request accepted when read & !waitrequest
mem_readdata  in  DEPTH*DATA_W  read data
mem_readdatavalid  in  1  read data valid
fifo_wdata  out  DATA_W  shared write data for all FIFOs
wrenA  out  N  per-A-FIFO write enable (one-hot or zero)
wrenB  out  1  B-FIFO write enable
fullA  in  N  A-FIFO full flags
fullB  in  1  B-FIFO full flag
emptyA  in  N  A-FIFO empty flags
emptyB  in  1  B-FIFO empty flag
rdenA  out  N  A-FIFO read enables (all equal)
rdenB  out  1  B-FIFO read enable
mac_clr  out  1  clear MAC accumulators (one cycle)
mac_en  out  1  MAC accumulate enable
cout_capture  out  1  one-cycle strobe; Cout registers latch MAC outputs
busy  out  1  high from start accept until DONE
done  out  1  high in DONE
err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset: state IDLE. All outputs 0; internal row, byte and pop counters 0. Reset asserted mid-run aborts immediately; FIFO contents are not the block's concern.
- State encodings (fixed, used by benches): IDLE=0, REQ=1, FILLA=2, FILLB=3, EXEC=4, DRAIN=5, DONE=6.
- IDLE/DONE + start: mac_clr=1 for one cycle, row=0, then go to REQ. A start pulse in any other state is ignored.
- REQ:
  - mem_address = row for row<N, else B_ADDR.
  - mem_read stays high until accepted.
  - On readdatavalid, latch the word and go to FILLA if row<N, else FILLB.
- FILLA/FILLB:
  - Byte k (k=0..DEPTH-1) is mem_readdata[k*DATA_W +: DATA_W]. It is written as entry k+1, one byte per cycle.
  - fifo_wdata is registered and aligned with wrenA[row] (or wrenB).
  - If the target FIFO's full flag is high, hold the byte and the wren is 0 (stall). There is no drop.
  - After byte DEPTH-1: row++. If row<N, go to REQ. If the A rows are done and B is not yet filled, go to REQ with the B address. After B is filled, go to EXEC.
- EXEC:
  - Each cycle that all emptyA==0 and emptyB==0: rdenA=all-ones and rdenB=1.
  - mac_en is asserted exactly 1 cycle after each pop (FIFO read latency 1).
  - After DEPTH pops, go to DRAIN.
- DRAIN: wait MAC_LAT cycles after the last mac_en, pulse cout_capture for 1 cycle, then go to DONE.
- DONE: done=1, busy=0. Stays in DONE until start or rst.
- mem_read, wrenA/B and rdenA/B are never active in the same cycle.
- mem_readdatavalid outside REQ is ignored.

Optional Feature:
- Macro: SEQ_READ_TIMEOUT_EN.
- Defined: a 16-bit watchdog counts cycles in REQ. If it reaches 1000 without readdatavalid, err=1 (sticky until start or rst) and the state goes to DONE with no cout_capture.
- Undefined: no watchdog; REQ waits indefinitely and err is tied 0.

Decomposition:
- Package mac_seq_pkg:
  - seq_state_t enum with the fixed encodings above
  - default constants for N, DEPTH, DATA_W
  - TIMEOUT_CYC=1000
- One sub-module, word_serializer:
  - loads a DEPTH*DATA_W word
  - emits bytes 0..DEPTH-1 with a stall input
  - last flag on the final byte

Test Plan:
1. Memory model: A row i = bytes 8i+1..8i+8, B = 1..8, no wait states; pulse start. Required: FIFO A0 receives entries 01..08, FIFO A1 receives 09..10h, B receives 01..08; after cout_capture, lane0=204 and lane1=492.
2. Hold mem_waitrequest high for 5 cycles on row 3. Required: mem_address=3 and mem_read stay stable; no wren activity; the final results equal those of test 1.
3. Force fullA[2] high for 4 cycles mid-fill. Required: wrenA[2]=0 and the byte is held during the stall; after release, the remaining bytes are in order with none lost.
4. EXEC with emptyB toggled high every other cycle. Required: rdenA/rdenB are asserted only when all FIFOs are non-empty; exactly 8 mac_en; cout_capture arrives MAC_LAT cycles after the last mac_en.
5. Assert rst during FILLA row 4. Required: the next cycle has state=0 and all outputs 0; a new start reruns and matches test 1.
6. With SEQ_READ_TIMEOUT_EN defined, never return readdatavalid. Required: err=1 and done=1 after 1000 cycles in REQ; cout_capture is never asserted.
